// File: rtl/hs32_arb_pkg.sv
// Shared types and default sizes for the HS32 two-port SRAM arbiter.
package hs32_arb_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    MGMT = 1'b1
  } owner_t;

endpackage

// File: rtl/hs32_rr_pick.sv
// Combinational 2-way round-robin pick; req_i[0] is the core, req_i[1] the management port.
module hs32_rr_pick
  import hs32_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // On a tie the side that did not win last time goes first.
      2'b11:   gnt_o = (last_i == MGMT) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/hs32_sram_arb.sv
// Arbitrates a core port and a management port onto one single-cycle SRAM,
// with a fixed IDLE -> ACCESS -> ACK sequence per transaction.
module hs32_sram_arb
  import hs32_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          c_stb,
  input  logic          c_rw,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_dtw,
  output logic [DW-1:0] c_dtr,
  output logic          c_ack,
  input  logic          m_stb,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_dat_i,
  output logic [DW-1:0] m_dat_o,
  output logic          m_ack,
  output logic          sram_csb,
  output logic          sram_web,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  owner_t        last_q,  last_d;
  logic          dir_q,   dir_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] data_q,  data_d;
  logic [1:0]    gnt;

  hs32_rr_pick u_pick (
    .req_i  ({m_stb, c_stb}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      owner_q <= CORE;
      last_q  <= MGMT;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // The captured request drives the SRAM bus directly; strobes only matter in IDLE.
  assign sram_addr = addr_q;
  assign sram_din  = data_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    dir_d    = dir_q;
    addr_d   = addr_q;
    data_d   = data_q;
    sram_csb = 1'b1;
    sram_web = 1'b1;
    c_ack    = 1'b0;
    m_ack    = 1'b0;
    c_dtr    = '0;
    m_dat_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[1] ? MGMT : CORE;
          last_d  = gnt[1] ? MGMT : CORE;
          dir_d   = gnt[1] ? m_we    : c_rw;
          addr_d  = gnt[1] ? m_addr  : c_addr;
          data_d  = gnt[1] ? m_dat_i : c_dtw;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        sram_csb = 1'b0;
        sram_web = ~dir_q;
        state_d  = ACK;
      end
      ACK: begin
        // SRAM read data lands this cycle; it is returned for writes too.
        if (owner_q == CORE) begin
          c_ack = 1'b1;
          c_dtr = sram_dout;
        end else begin
          m_ack   = 1'b1;
          m_dat_o = sram_dout;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hs32_sram_arb.sv
// Randomized and directed bench for hs32_sram_arb against a transaction-timeline model.
module tb_hs32_sram_arb;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetb;
  logic          c_stb, c_rw, c_ack;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_dtw, c_dtr;
  logic          m_stb, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dat_i, m_dat_o;
  logic          sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  hs32_sram_arb #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .c_stb     (c_stb),
    .c_rw      (c_rw),
    .c_addr    (c_addr),
    .c_dtw     (c_dtw),
    .c_dtr     (c_dtr),
    .c_ack     (c_ack),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_dat_i   (m_dat_i),
    .m_dat_o   (m_dat_o),
    .m_ack     (m_ack),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a) * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  // Behavioural single-cycle SRAM: read data appears the cycle after the access.
  logic [DW-1:0] mem [0:255];
  bit            mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
      sram_dout <= $urandom;
    end else if (!sram_csb) begin
      if (!sram_web) begin
        mem[sram_addr] <= sram_din;
        sram_dout      <= sram_din;
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end else begin
      sram_dout <= $urandom;
    end
  end

  int n_vec, n_err;
  int cyc, free_at;
  bit pv, p_own, p_rw, last_own;
  int p_g;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data, p_rd;
  logic [DW-1:0] ref_mem [0:255];
  int gq[$];
  bit c_act, m_act, rand_en, hold_both, ack_c, ack_m;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit in_acc, in_ack;
    in_acc = pv && (cyc == p_g + 1);
    in_ack = pv && (cyc == p_g + 2);
    check_eq("sram_csb", DW'(sram_csb), DW'(!in_acc));
    check_eq("sram_web", DW'(sram_web), DW'(!(in_acc && p_rw)));
    if (in_acc) begin
      check_eq("sram_addr", DW'(sram_addr), DW'(p_addr));
      if (p_rw) check_eq("sram_din", sram_din, p_data);
    end
    ack_c = in_ack && !p_own;
    ack_m = in_ack && p_own;
    check_eq("c_ack", DW'(c_ack), DW'(ack_c));
    check_eq("m_ack", DW'(m_ack), DW'(ack_m));
    check_eq("c_dtr", c_dtr, ack_c ? p_rd : '0);
    check_eq("m_dat_o", m_dat_o, ack_m ? p_rd : '0);
    if (in_ack) pv = 1'b0;
  endtask

  task automatic start_c();
    c_act = 1'b1; c_stb = 1'b1; c_rw = 1'($urandom);
    c_addr = AW'($urandom_range(0, 15)); c_dtw = $urandom;
  endtask

  task automatic start_m();
    m_act = 1'b1; m_stb = 1'b1; m_we = 1'($urandom);
    m_addr = AW'($urandom_range(0, 15)); m_dat_i = $urandom;
  endtask

  task automatic issue_c(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_act = 1'b1; c_stb = 1'b1; c_rw = rw; c_addr = a; c_dtw = d;
  endtask

  task automatic issue_m(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_act = 1'b1; m_stb = 1'b1; m_we = rw; m_addr = a; m_dat_i = d;
  endtask

  task automatic agent();
    if (ack_c) begin c_act = 1'b0; c_stb = 1'b0; if (hold_both) start_c(); end
    if (ack_m) begin m_act = 1'b0; m_stb = 1'b0; if (hold_both) start_m(); end
    if (rand_en) begin
      if (!c_act) begin
        if ($urandom_range(0, 9) < 4) start_c();
      end else if (pv && !p_own && cyc == p_g + 1) begin
        if ($urandom_range(0, 4) == 0) c_stb = 1'b0;
        c_rw = 1'($urandom); c_addr = AW'($urandom); c_dtw = $urandom;
      end
      if (!m_act) begin
        if ($urandom_range(0, 9) < 4) start_m();
      end else if (pv && p_own && cyc == p_g + 1) begin
        if ($urandom_range(0, 4) == 0) m_stb = 1'b0;
        m_we = 1'($urandom); m_addr = AW'($urandom); m_dat_i = $urandom;
      end
    end
  endtask

  // Transaction timeline: a grant at cycle g means access at g+1, ack at g+2, free at g+3.
  task automatic model_edge();
    bit own;
    if (resetb && cyc >= free_at && (c_stb || m_stb)) begin
      if (c_stb && m_stb) own = !last_own;
      else                own = m_stb;
      pv     = 1'b1;
      p_own  = own;
      p_g    = cyc;
      p_rw   = own ? m_we    : c_rw;
      p_addr = own ? m_addr  : c_addr;
      p_data = own ? m_dat_i : c_dtw;
      p_rd   = p_rw ? p_data : ref_mem[p_addr];
      if (p_rw) ref_mem[p_addr] = p_data;
      last_own = own;
      free_at  = cyc + 3;
      gq.push_back(int'(own));
    end
  endtask

  task automatic step();
    check_cycle();
    agent();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    pv = 1'b0; last_own = 1'b1; ack_c = 1'b0; ack_m = 1'b0;
  endtask

  task automatic release_reset();
    resetb = 1'b1; free_at = cyc;
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] wd;
    c_stb = 0; c_rw = 0; c_addr = '0; c_dtw = '0;
    m_stb = 0; m_we = 0; m_addr = '0; m_dat_i = '0;
    resetb = 1'b1;
    n_vec = 0; n_err = 0; cyc = 0; free_at = 0; p_g = 0;
    c_act = 0; m_act = 0; rand_en = 0; hold_both = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    #2 resetb = 1'b0;
    @(negedge clk);
    repeat (3) step();
    check_eq("rst_addr", DW'(sram_addr), '0);
    check_eq("rst_din", sram_din, '0);
    release_reset();

    // Core write 0x10 <- 0xFF00
    issue_c(1'b1, 8'h10, 32'h0000_FF00);
    step();
    check_eq("w_csb", DW'(sram_csb), '0);
    check_eq("w_web", DW'(sram_web), '0);
    check_eq("w_addr", DW'(sram_addr), 32'h10);
    step();
    check_eq("w_cack", DW'(c_ack), 32'd1);
    check_eq("w_mack", DW'(m_ack), '0);
    repeat (2) step();

    // Core read back 0x10
    issue_c(1'b0, 8'h10, '0);
    repeat (2) step();
    check_eq("r_cack", DW'(c_ack), 32'd1);
    check_eq("r_dtr", c_dtr, 32'h0000_FF00);
    repeat (2) step();

    // Both requesting from reset: strict alternation starting with the core
    resetb = 1'b0; model_reset(); c_stb = 0; c_act = 0;
    repeat (2) step();
    release_reset();
    gq.delete();
    hold_both = 1'b1;
    start_c(); start_m();
    repeat (12) step();
    hold_both = 1'b0;
    c_stb = 0; m_stb = 0; c_act = 0; m_act = 0;
    check_eq("rr_n", DW'(gq.size()), 32'd4);
    check_eq("rr_0", DW'(gq[0]), 32'd0);
    check_eq("rr_1", DW'(gq[1]), 32'd1);
    check_eq("rr_2", DW'(gq[2]), 32'd0);
    check_eq("rr_3", DW'(gq[3]), 32'd1);
    repeat (2) step();

    // Management write with strobe dropped during ACCESS
    wd = $urandom;
    issue_m(1'b1, 8'h22, wd);
    step();
    m_stb = 1'b0;
    cnt = 0;
    repeat (6) begin
      step();
      if (m_ack) cnt++;
    end
    check_eq("drop_mack_cnt", DW'(cnt), 32'd1);
    issue_c(1'b0, 8'h22, '0);
    repeat (2) step();
    check_eq("drop_rdback", c_dtr, wd);
    repeat (2) step();

    // Reset during ACCESS, core strobe left pending
    issue_c(1'b0, 8'h10, '0);
    step();
    resetb = 1'b0;
    #1;
    check_eq("ra_csb", DW'(sram_csb), 32'd1);
    check_eq("ra_cack", DW'(c_ack), '0);
    model_reset();
    @(negedge clk);
    repeat (2) step();
    release_reset();
    repeat (2) step();
    check_eq("ra_cack2", DW'(c_ack), 32'd1);
    check_eq("ra_dtr", c_dtr, 32'h0000_FF00);
    repeat (2) step();

    // Random traffic
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hs32_sram_arb.md
HS32_SRAM_ARB -- requirements
Module: hs32_sram_arb

Interface
REQ-001 Parameter: AW, 8, SRAM word-address width.
REQ-002 Parameter: DW, 32, data width.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: resetb  input  1  asynchronous, active-low reset.
REQ-005 Port: c_stb  input  1  core request strobe, held until c_ack.
REQ-006 Port: c_rw  input  1  core direction, 1=write, 0=read.
REQ-007 Port: c_addr  input  AW  core word address.
REQ-008 Port: c_dtw  input  DW  core write data.
REQ-009 Port: c_dtr  output  DW  core read data, valid while c_ack=1.
REQ-010 Port: c_ack  output  1  core completion pulse.
REQ-011 Port: m_stb  input  1  management (Wishbone-side) request strobe, held until m_ack.
REQ-012 Port: m_we  input  1  management direction, 1=write.
REQ-013 Port: m_addr  input  AW  management word address.
REQ-014 Port: m_dat_i  input  DW  management write data.
REQ-015 Port: m_dat_o  output  DW  management read data, valid while m_ack=1.
REQ-016 Port: m_ack  output  1  management completion pulse.
REQ-017 Port: sram_csb  output  1  SRAM chip select, active-low.
REQ-018 Port: sram_web  output  1  SRAM write enable, active-low.
REQ-019 Port: sram_addr  output  AW  SRAM address.
REQ-020 Port: sram_din  output  DW  SRAM write data.
REQ-021 Port: sram_dout  input  DW  SRAM read data, valid one cycle after the access cycle.

Function
REQ-022 The FSM SHALL have states IDLE, ACCESS, ACK; the owner SHALL be encoded as CORE or MGMT.
REQ-023 IDLE: if any stb=1, the FSM SHALL register the winner and captured addr/data/direction, then go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-024 ACCESS SHALL last exactly one cycle: sram_csb=0, sram_web=!dir, sram_addr/sram_din from the captured values; then go to ACK.
REQ-025 ACK SHALL last exactly one cycle: the owner's ack=1, the owner's read data=sram_dout (reads and writes alike); then go to IDLE.
REQ-026 Latency SHALL be fixed: stb sampled high at edge N, ack high in cycle N+2; maximum throughput is one access per 3 cycles.
REQ-027 With both stb=1 in IDLE, the grant SHALL go to the requester not granted last (round robin); after reset, last-grant=MGMT, so the core wins the first tie.
REQ-028 A single requester SHALL be granted regardless of last-grant.
REQ-029 Outside ACCESS, sram_csb=1 and sram_web=1.
REQ-030 At most one ack SHALL be high in any cycle, and the non-owner's ack SHALL stay 0.
REQ-031 Requests SHALL be captured only in IDLE; stb/address/data changes during ACCESS/ACK SHALL be ignored.
REQ-032 A stb dropped after capture SHALL NOT abort the access; ack still pulses once.
REQ-033 A stb still high in the cycle after ack SHALL be treated as a new request.
REQ-034 Read-data outputs SHALL be 0 when their ack is 0.

Reset
REQ-035 While resetb=0, the FSM SHALL be in IDLE, last-grant=MGMT, c_ack=m_ack=0, sram_csb=sram_web=1, and sram_addr, sram_din, c_dtr, m_dat_o =0.
REQ-036 Reset asserted during ACCESS or ACK SHALL drop the transaction immediately with no ack; after release, operation SHALL resume from IDLE.

Structure
REQ-037 Package hs32_arb_pkg SHALL hold the state enum, the owner enum (CORE/MGMT) and default AW/DW constants.
REQ-038 Sub-module hs32_rr_pick SHALL provide the combinational 2-way round-robin pick (req[1:0], last -> grant); all registers stay in hs32_sram_arb.

Verification
REQ-039 Core write addr 0x10 data 0xFF00 -> sram_csb=0, sram_web=0, addr 0x10 at N+1; c_ack at N+2; m_ack stays 0.
REQ-040 Core read back 0x10 -> c_ack with c_dtr=0xFF00 at N+2; c_dtr=0 on other cycles.
REQ-041 Both stb=1 after reset, held continuously -> grant order CORE, MGMT, CORE, MGMT; one ack per 3 cycles.
REQ-042 m_stb dropped during ACCESS -> SRAM write completes and m_ack pulses once; no second access follows.
REQ-043 resetb=0 during ACCESS -> no ack, sram_csb=1 immediately; after release, a pending c_stb is served with c_ack 2 cycles later.
